// File: rtl/lgs_bench_pkg.sv
// Shared constants, width helpers and FIFO entry layout for the grant-controller benchmarks.
package lgs_bench_pkg;

    localparam int unsigned NChDefault     = 4;
    localparam int unsigned DwDefault      = 8;
    localparam int unsigned DepthDefault   = 4;
    localparam int unsigned CreditsDefault = 3;

    // Smallest n with 2**n >= value; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // A FIFO entry is {ch, data}: channel index in the upper bits, payload in the lower DW bits.
    function automatic int unsigned entry_width(input int unsigned nch, input int unsigned dw);
        return clog2(nch) + dw;
    endfunction

    typedef struct packed {
        logic [clog2(NChDefault)-1:0] ch;
        logic [DwDefault-1:0]         data;
    } grant_entry_t;

endpackage

// File: rtl/multi_chan_grant_ctrl_if.sv
// Request/grant, credit and output-stream signals of the multi-channel grant controller.
interface multi_chan_grant_ctrl_if #(
    parameter int unsigned NCH   = lgs_bench_pkg::NChDefault,
    parameter int unsigned DW    = lgs_bench_pkg::DwDefault,
    parameter int unsigned DEPTH = lgs_bench_pkg::DepthDefault
);

    localparam int unsigned ChW  = lgs_bench_pkg::clog2(NCH);
    localparam int unsigned LvlW = lgs_bench_pkg::clog2(DEPTH) + 1;

    logic [NCH-1:0]    req_valid;
    logic [NCH*DW-1:0] req_data;
    logic [NCH-1:0]    req_ready;
    logic [NCH-1:0]    credit_ret;
    logic              mode;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [ChW-1:0]    out_ch;
    logic [LvlW-1:0]   fifo_level;
    logic              busy;

    modport master (
        output req_valid, req_data, credit_ret, mode, out_ready,
        input  req_ready, out_valid, out_data, out_ch, fifo_level, busy
    );

    modport slave (
        input  req_valid, req_data, credit_ret, mode, out_ready,
        output req_ready, out_valid, out_data, out_ch, fifo_level, busy
    );

endinterface

// File: rtl/sync_fifo_reg.sv
// Shift-register FIFO whose head entry is always slot 0, so the read side comes straight from flops.
module sync_fifo_reg
    import lgs_bench_pkg::*;
#(
    parameter int unsigned DEPTH = DepthDefault,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned LvlW = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [LvlW-1:0]  level_o,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [LvlW-1:0]  level_q, level_d;
    logic             valid_q, valid_d;
    logic [LvlW-1:0]  wr_idx;
    logic             push_ok, pop_ok;

    // A push while full is refused even if the head is popped in the same cycle.
    assign full_o  = (level_q == LvlW'(DEPTH));
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && valid_q;

    always_comb begin
        mem_d   = mem_q;
        level_d = level_q;
        wr_idx  = level_q;
        if (pop_ok) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[DEPTH-1] = '0;
            level_d        = level_d - 1'b1;
            wr_idx         = level_q - 1'b1;
        end
        if (push_ok) begin
            mem_d[wr_idx[LvlW-2:0]] = wdata_i;
            level_d                 = level_d + 1'b1;
        end
    end

    assign valid_d = (level_d != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            level_q <= '0;
            valid_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            level_q <= level_d;
            valid_q <= valid_d;
        end
    end

    assign empty_o = !valid_q;
    assign level_o = level_q;
    assign rdata_o = mem_q[0];

endmodule

// File: rtl/multi_chan_grant_ctrl.sv
// Credit-gated fixed-priority / round-robin arbiter over NCH channels feeding a registered FIFO.
module multi_chan_grant_ctrl
    import lgs_bench_pkg::*;
#(
    parameter int unsigned NCH     = NChDefault,
    parameter int unsigned DW      = DwDefault,
    parameter int unsigned DEPTH   = DepthDefault,
    parameter int unsigned CREDITS = CreditsDefault
) (
    input logic                    clk,
    input logic                    rst_n,
    multi_chan_grant_ctrl_if.slave bus
);

    localparam int unsigned ChW  = clog2(NCH);
    localparam int unsigned EntW = entry_width(NCH, DW);
    localparam int unsigned LvlW = clog2(DEPTH) + 1;
    localparam int unsigned CrW  = clog2(CREDITS + 1);

    logic [NCH-1:0]  elig, fp_win, rr_win, grant;
    logic [ChW-1:0]  ptr_q, ptr_d, gnt_idx;
    logic [DW-1:0]   gnt_data;
    logic            gnt_any;
    logic            fifo_full, fifo_empty;
    logic [LvlW-1:0] fifo_level;
    logic [EntW-1:0] head;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CrW-1:0] credit_q, credit_d;
        logic           rr_blocked;

        // Reset gates eligibility so no grant is visible while rst_n is low.
        assign elig[i]   = rst_n && bus.req_valid[i] && (credit_q != '0) && !fifo_full;
        assign fp_win[i] = elig[i] && ((elig & NCH'((1 << i) - 1)) == '0);

        // Round-robin: blocked by any eligible channel closer to ptr in cyclic order.
        always_comb begin
            int unsigned dist_i;
            int unsigned dist_j;
            rr_blocked = 1'b0;
            dist_i     = (i + NCH - 32'(ptr_q)) % NCH;
            for (int unsigned j = 0; j < NCH; j++) begin
                dist_j = (j + NCH - 32'(ptr_q)) % NCH;
                if (elig[j] && (dist_j < dist_i)) begin
                    rr_blocked = 1'b1;
                end
            end
        end

        assign rr_win[i] = elig[i] && !rr_blocked;
        assign grant[i]  = bus.mode ? rr_win[i] : fp_win[i];

        always_comb begin
            credit_d = credit_q;
            case ({grant[i], bus.credit_ret[i]})
                2'b10: credit_d = credit_q - 1'b1;
                2'b01: begin
                    if (credit_q != CrW'(CREDITS)) begin
                        credit_d = credit_q + 1'b1;
                    end
                end
                default: credit_d = credit_q;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                credit_q <= CrW'(CREDITS);
            end else begin
                credit_q <= credit_d;
            end
        end
    end

    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                gnt_idx  = ChW'(i);
                gnt_data = bus.req_data[i*DW +: DW];
            end
        end
    end

    assign gnt_any = |grant;

    always_comb begin
        ptr_d = ptr_q;
        if (bus.mode && gnt_any) begin
            ptr_d = (32'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    sync_fifo_reg #(
        .DEPTH (DEPTH),
        .WIDTH (EntW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (gnt_any),
        .wdata_i ({gnt_idx, gnt_data}),
        .pop_i   (bus.out_ready),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level),
        .rdata_o (head)
    );

    assign bus.req_ready  = grant;
    assign bus.out_valid  = !fifo_empty;
    assign bus.out_data   = head[DW-1:0];
    assign bus.out_ch     = head[EntW-1:DW];
    assign bus.fifo_level = fifo_level;
    assign bus.busy       = rst_n && (!fifo_empty || (|bus.req_valid));

endmodule

// File: tb/tb_multi_chan_grant_ctrl.sv
// Directed and random stimulus for multi_chan_grant_ctrl checked against a queue-based model.
module tb_multi_chan_grant_ctrl;

    localparam int unsigned NCH     = 4;
    localparam int unsigned DW      = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CREDITS = 3;
    localparam int unsigned ChW     = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    multi_chan_grant_ctrl_if #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) bus ();

    multi_chan_grant_ctrl #(
        .NCH     (NCH),
        .DW      (DW),
        .DEPTH   (DEPTH),
        .CREDITS (CREDITS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    int                  cred [NCH];
    int                  ptr;
    logic [ChW+DW-1:0]   q [$];
    int                  hist1, hist2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        bit el [NCH];
        for (int i = 0; i < NCH; i++) begin
            el[i] = rst_n && bus.req_valid[i] && (cred[i] > 0) && (q.size() < DEPTH);
        end
        if (!bus.mode) begin
            for (int i = 0; i < NCH; i++) if (el[i]) return i;
        end else begin
            for (int k = 0; k < NCH; k++) if (el[(ptr + k) % NCH]) return (ptr + k) % NCH;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        q.delete();
        for (int i = 0; i < NCH; i++) cred[i] = CREDITS;
        ptr   = 0;
        hist1 = -1;
        hist2 = -1;
    endfunction

    // One clock: check outputs mid-cycle, then advance model across the rising edge.
    task automatic step(output logic [NCH-1:0] obs_rdy);
        int                g;
        logic [ChW+DW-1:0] head;
        logic [ChW+DW-1:0] entry;
        #4;
        g       = model_grant();
        obs_rdy = bus.req_ready;
        check("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            head = q[0];
            check("out_data", 32'(bus.out_data), 32'(head[DW-1:0]));
            check("out_ch", 32'(bus.out_ch), 32'(head[DW +: ChW]));
        end
        check("fifo_level", 32'(bus.fifo_level), 32'(q.size()));
        check("busy", 32'(bus.busy), 32'((q.size() != 0) || (bus.req_valid != '0)));
        entry = '0;
        if (g >= 0) entry = {ChW'(g), bus.req_data[g*DW +: DW]};
        @(posedge clk);
        #1;
        if ((q.size() != 0) && bus.out_ready) void'(q.pop_front());
        if (g >= 0) q.push_back(entry);
        for (int i = 0; i < NCH; i++) begin
            if ((g == i) && !bus.credit_ret[i]) cred[i]--;
            else if ((g != i) && bus.credit_ret[i] && (cred[i] < CREDITS)) cred[i]++;
        end
        if (bus.mode && (g >= 0)) ptr = (g + 1) % NCH;
        hist2 = hist1;
        hist1 = g;
    endtask

    // Asserts reset mid-cycle with inputs untouched, checks outputs clear at once, then releases.
    task automatic reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_ch", 32'(bus.out_ch), 32'd0);
        check("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        model_reset();
        bus.req_valid  = '0;
        bus.credit_ret = '0;
        bus.out_ready  = 1'b0;
        bus.mode       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NCH-1:0] rdy;
        logic [DW-1:0]  first_data;
        logic [3:0]     t2_exp [6];
        logic [3:0]     t5_exp [5];
        t2_exp = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b1000};
        t5_exp = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};

        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.credit_ret = '0;
        bus.mode       = 1'b0;
        bus.out_ready  = 1'b0;
        model_reset();
        #3;
        check("init_out_valid", 32'(bus.out_valid), 32'd0);
        check("init_fifo_level", 32'(bus.fifo_level), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1. Build up level 3, then reset in the middle of traffic.
        bus.req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            bus.req_data = $urandom();
            step(rdy);
        end
        check("t1_level3", 32'(bus.fifo_level), 32'd3);
        reset_mid();

        // 2. Fixed priority with ch1 and ch3 requesting.
        bus.mode      = 1'b0;
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            bus.req_data = $urandom();
            step(rdy);
            check("t2_grant_seq", 32'(rdy), 32'(t2_exp[k]));
        end
        bus.req_valid = '0;
        step(rdy);
        step(rdy);
        reset_mid();

        // 3. Round-robin with all channels requesting, credits returned two cycles later.
        bus.mode      = 1'b1;
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            bus.req_data   = $urandom();
            bus.credit_ret = (hist2 >= 0) ? NCH'(1 << hist2) : '0;
            step(rdy);
            check("t3_rr_order", 32'(rdy), 32'd1 << (k % NCH));
        end
        reset_mid();

        // 4. Fill the FIFO with the sink stalled, then release one slot.
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            bus.req_data = $urandom();
            step(rdy);
        end
        check("t4_full_level", 32'(bus.fifo_level), 32'd4);
        step(rdy);
        check("t4_full_no_grant", 32'(rdy), 32'd0);
        bus.out_ready = 1'b1;
        step(rdy);
        check("t4_full_pop_no_push", 32'(rdy), 32'd0);
        bus.out_ready = 1'b0;
        check("t4_level_after_pop", 32'(bus.fifo_level), 32'd3);
        step(rdy);
        check("t4_new_grant", 32'(rdy), 32'b0010);
        reset_mid();

        // 5. Credit saturation and simultaneous grant/return on ch2.
        bus.out_ready  = 1'b1;
        bus.credit_ret = 4'b0100;
        step(rdy);
        bus.credit_ret = '0;
        bus.req_valid  = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            bus.req_data   = $urandom();
            bus.credit_ret = (k == 2) ? 4'b0100 : 4'b0000;
            step(rdy);
            check("t5_credit_grants", 32'(rdy), 32'(t5_exp[k]));
        end
        bus.req_valid  = '0;
        bus.credit_ret = '0;
        reset_mid();

        // 6. Backpressure: head must hold for 10 stalled cycles, then drain in order.
        bus.req_valid = 4'b0001;
        first_data    = 8'h00;
        for (int k = 0; k < 3; k++) begin
            bus.req_data = {24'h0, 8'(8'h5A + 8'(k * 17))};
            if (k == 0) first_data = bus.req_data[7:0];
            step(rdy);
        end
        bus.req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            step(rdy);
            check("t6_hold_data", 32'(bus.out_data), 32'(first_data));
            check("t6_hold_ch", 32'(bus.out_ch), 32'd0);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step(rdy);
        reset_mid();

        // 7. Random traffic with mode flips, credit returns and one mid-run reset.
        for (int k = 0; k < 400; k++) begin
            bus.req_valid  = NCH'($urandom());
            bus.req_data   = $urandom();
            bus.out_ready  = ($urandom_range(0, 2) != 0);
            bus.credit_ret = NCH'($urandom() & $urandom());
            if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
            step(rdy);
            if (k == 200) reset_mid();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
